signal_stim: RTL and testbench

SIGNAL_STIM -- requirements
Module: signal_stim

---
 rtl/signal_check_pkg.sv | 19 +
 rtl/signal_stim_if.sv | 26 ++
 rtl/signal_stim_lfsr.sv | 28 ++
 rtl/signal_stim.sv | 144 ++++++++++++++
 tb/tb_signal_stim.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/signal_check_pkg.sv
// Shared FSM state type, LFSR constants and helpers for the signal stimulus generator.
package signal_check_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_DEFAULT_SEED = 8'h01;
  localparam int         CHK_LAT           = 2;

  function automatic logic [7:0] lfsrNext(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

  // An all-zero Galois LFSR never leaves zero, so substitute the default seed.
  function automatic logic [7:0] seedFix(input logic [7:0] seed);
    return (seed == 8'h00) ? LFSR_DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/signal_stim_if.sv
// Bus between the stimulus generator and its environment (request, stimulus, verdicts, status).
interface signal_stim_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] length;
  logic [7:0]       seed;
  logic             signal_out;
  logic             en_out;
  logic             match_in;
  logic             fail_in;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] ones_cnt;
  logic [LEN_W-1:0] err_cnt;

  modport master (
    output start, length, seed, match_in, fail_in,
    input  signal_out, en_out, busy, done, ones_cnt, err_cnt
  );

  modport slave (
    input  start, length, seed, match_in, fail_in,
    output signal_out, en_out, busy, done, ones_cnt, err_cnt
  );
endinterface

// File: rtl/signal_stim_lfsr.sv
// 8-bit Galois right-shift LFSR; load and step together loads the seed and advances it once.
module signal_stim_lfsr
  import signal_check_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [7:0] i_seed,
  output logic [7:0] o_state
);

  logic [7:0] r_state;
  logic [7:0] w_base;

  assign w_base = i_load ? i_seed : r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LFSR_DEFAULT_SEED;
    end else if (i_load || i_step) begin
      r_state <= i_step ? lfsrNext(w_base) : w_base;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/signal_stim.sv
// LFSR burst stimulus generator that scores the checker's delayed verdicts.
// Optional macro SIGNAL_STIM_ERR_INJECT_EN inverts driven burst bit INJ_IDX on signal_out.
module signal_stim
  import signal_check_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int INJ_IDX = 3
) (
  input logic          clk,
  input logic          rst_n,
  signal_stim_if.slave bus
);

  state_t           r_state, w_stateNext;
  logic [LEN_W-1:0] r_cnt, w_cntNext;
  logic             w_accept, w_drive;
  logic [7:0]       w_seedEff, w_lfsrState;
  logic [6:0]       w_unusedLfsrHi;
  logic             w_curBit, w_drivenBit;
  logic             r_trueBit, r_sigOut, r_enOut;
  logic [1:0]       r_pipeBit, r_pipeEn;
  logic [LEN_W-1:0] r_onesCnt, r_errCnt;
  logic             w_errHit, w_oneHit;

  assign w_seedEff      = seedFix(bus.seed);
  assign w_curBit       = w_accept ? w_seedEff[0] : w_lfsrState[0];
  assign w_unusedLfsrHi = w_lfsrState[7:1];

  signal_stim_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_step (w_drive),
    .i_seed (w_seedEff),
    .o_state(w_lfsrState)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // The first bit is driven on the accepting edge, so r_cnt holds bits still owed including it.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_accept    = 1'b0;
    w_drive     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (bus.length != '0) begin
            w_stateNext = RUN;
            w_cntNext   = bus.length;
            w_drive     = 1'b1;
          end else begin
            w_stateNext = DONE;
          end
        end
      end
      RUN: begin
        if (r_cnt == LEN_W'(1)) begin
          w_stateNext = DRAIN;
          w_cntNext   = LEN_W'(CHK_LAT - 1);
        end else begin
          w_cntNext = r_cnt - LEN_W'(1);
          w_drive   = 1'b1;
        end
      end
      DRAIN: begin
        if (r_cnt == '0) begin
          w_stateNext = DONE;
        end else begin
          w_cntNext = r_cnt - LEN_W'(1);
        end
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

`ifdef SIGNAL_STIM_ERR_INJECT_EN
  logic [LEN_W-1:0] r_bitIdx;
  logic [LEN_W-1:0] w_bitIdx;

  assign w_bitIdx    = w_accept ? '0 : r_bitIdx;
  assign w_drivenBit = w_curBit ^ (w_drive && (int'(w_bitIdx) == INJ_IDX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bitIdx <= '0;
    end else if (w_drive) begin
      r_bitIdx <= w_bitIdx + LEN_W'(1);
    end
  end
`else
  localparam int unusedInjIdx = INJ_IDX;
  assign w_drivenBit = w_curBit;
`endif

  // Verdicts for a bit arrive CHK_LAT cycles after it is driven; pipeline stage 2 lines up with them.
  assign w_errHit = r_pipeEn[1] ? !((bus.match_in == r_pipeBit[1]) && (bus.fail_in == !r_pipeBit[1]))
                                : (bus.match_in || bus.fail_in);
  assign w_oneHit = r_pipeEn[1] && bus.match_in && r_pipeBit[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trueBit <= 1'b0;
      r_sigOut  <= 1'b0;
      r_enOut   <= 1'b0;
      r_pipeBit <= '0;
      r_pipeEn  <= '0;
      r_onesCnt <= '0;
      r_errCnt  <= '0;
    end else begin
      r_trueBit <= w_drive & w_curBit;
      r_sigOut  <= w_drive & w_drivenBit;
      r_enOut   <= w_drive;
      r_pipeBit <= {r_pipeBit[0], r_trueBit};
      r_pipeEn  <= {r_pipeEn[0], r_enOut};
      if (w_accept) begin
        r_onesCnt <= '0;
        r_errCnt  <= '0;
      end else begin
        if (w_oneHit && (r_onesCnt != '1)) r_onesCnt <= r_onesCnt + LEN_W'(1);
        if (w_errHit && (r_errCnt != '1))  r_errCnt  <= r_errCnt + LEN_W'(1);
      end
    end
  end

  assign bus.signal_out = r_sigOut;
  assign bus.en_out     = r_enOut;
  assign bus.busy       = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done       = (r_state == DONE);
  assign bus.ones_cnt   = r_onesCnt;
  assign bus.err_cnt    = r_errCnt;

endmodule

// File: tb/tb_signal_stim.sv
// Randomized self-checking bench for signal_stim with a 2-cycle loopback checker model.
`timescale 1ns/1ps
module tb_signal_stim;

  localparam int LEN_W   = 8;
  localparam int INJ_IDX = 3;
`ifdef SIGNAL_STIM_ERR_INJECT_EN
  localparam bit INJ_ON = 1'b1;
`else
  localparam bit INJ_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic forceMatch = 1'b0;
  logic [1:0] chkBit, chkEn;
  int testsRun = 0;
  int testsFailed = 0;

  bit   expDriven[256];
  int   expOnes, expErr;
  logic [7:0] lastPattern;

  signal_stim_if #(.LEN_W(LEN_W)) bus ();

  signal_stim #(.LEN_W(LEN_W), .INJ_IDX(INJ_IDX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Loopback checker: reports match = driven bit, fail = its inverse, two cycles later.
  always @(posedge clk) begin
    if (!rst_n) begin
      chkBit <= '0;
      chkEn  <= '0;
    end else begin
      chkBit <= {chkBit[0], bus.signal_out};
      chkEn  <= {chkEn[0], bus.en_out};
    end
  end
  assign bus.match_in = forceMatch | (chkEn[1] & chkBit[1]);
  assign bus.fail_in  = chkEn[1] & ~chkBit[1];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic computeModel(input logic [7:0] seed, input int len);
    logic [7:0] s;
    bit t, d;
    s = (seed == 8'h00) ? 8'h01 : seed;
    expOnes = 0;
    expErr  = 0;
    for (int i = 0; i < len; i++) begin
      t = s[0];
      d = t ^ (INJ_ON && (i == INJ_IDX));
      expDriven[i] = d;
      if (d && t) expOnes++;
      if (d != t) expErr++;
      s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] seed, input int len, input bit pulseWhileBusy);
    int doneAt;
    computeModel(seed, len);
    doneAt = (len == 0) ? 1 : len + 3;
    lastPattern = '0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.length = LEN_W'(len);
    bus.seed   = seed;
    @(negedge clk);
    for (int n = 1; n <= doneAt; n++) begin
      checkOutput("en_out", bus.en_out, (n <= len));
      checkOutput("signal_out", bus.signal_out, (n <= len) ? expDriven[n-1] : 1'b0);
      checkOutput("busy", bus.busy, (len != 0) && (n <= len + 2));
      checkOutput("done", bus.done, (n == doneAt));
      if (n <= 8) lastPattern[n-1] = bus.signal_out;
      bus.start  = pulseWhileBusy && (n == 3 || n == doneAt);
      bus.length = LEN_W'($urandom_range(1, 40));
      bus.seed   = 8'($urandom);
      if (n != doneAt) @(negedge clk);
    end
    checkOutput("ones_cnt", bus.ones_cnt, expOnes);
    checkOutput("err_cnt", bus.err_cnt, expErr);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("done_drop", bus.done, 1'b0);
    checkOutput("idle_busy", bus.busy, 1'b0);
    checkOutput("ones_stable", bus.ones_cnt, expOnes);
    checkOutput("err_stable", bus.err_cnt, expErr);
    @(negedge clk);
    checkOutput("idle_en", bus.en_out, 1'b0);
    checkOutput("idle_busy2", bus.busy, 1'b0);
  endtask

  task automatic applyResetMidBurst(input logic [7:0] seed, input int len);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.length = LEN_W'(len);
    bus.seed   = seed;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n < 4; n++) @(negedge clk);
    checkOutput("rst_run_en", bus.en_out, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_sig", bus.signal_out, 1'b0);
    checkOutput("rst_en", bus.en_out, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOutput("rst_ones", bus.ones_cnt, 0);
    checkOutput("rst_err", bus.err_cnt, 0);
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      checkOutput("rst_no_done", bus.done, 1'b0);
    end
  endtask

  task automatic applyForcedMatch(input int cycles, input int baseErr);
    int expVal;
    @(negedge clk);
    forceMatch = 1'b1;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      expVal = (baseErr + i > 255) ? 255 : baseErr + i;
      if (i <= 4 || i == cycles) checkOutput("force_err", bus.err_cnt, expVal);
    end
    forceMatch = 1'b0;
    checkOutput("force_ones", bus.ones_cnt, expOnes);
  endtask

  initial begin
    logic [7:0] rSeed;
    int rLen;
    bus.start  = 1'b0;
    bus.length = '0;
    bus.seed   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sig", bus.signal_out, 1'b0);
    checkOutput("reset_en", bus.en_out, 1'b0);
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_done", bus.done, 1'b0);
    checkOutput("reset_ones", bus.ones_cnt, 0);
    checkOutput("reset_err", bus.err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'h01, 8, 1'b0);
    checkOutput("pattern_s01", lastPattern, INJ_ON ? 8'h79 : 8'h71);
    checkOutput("ones_s01", bus.ones_cnt, 4);
    checkOutput("err_s01", bus.err_cnt, INJ_ON ? 1 : 0);

    applyStimulus(8'h00, 8, 1'b0);
    checkOutput("pattern_s00", lastPattern, INJ_ON ? 8'h79 : 8'h71);

    applyStimulus(8'h5A, 0, 1'b1);
    applyStimulus(8'hC3, 1, 1'b1);

    applyForcedMatch(5, expErr);
    applyForcedMatch(300, expErr + 5);

    applyResetMidBurst(8'h01, 8);
    applyStimulus(8'h01, 8, 1'b1);

    for (int k = 0; k < 16; k++) begin
      rSeed = 8'($urandom_range(0, 255));
      rLen  = $urandom_range(0, 20);
      applyStimulus(rSeed, rLen, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
